// File: rtl/mapu_pkg.sv
// Shared definitions for the matrix APU and its row packer: op encodings,
// packer FSM states and the fixed job geometry.
package mapu_pkg;

    localparam logic MAPU_OP_ADD  = 1'b0;
    localparam logic MAPU_OP_MULT = 1'b1;

    localparam int ROWS_PER_JOB  = 8;
    localparam int ELEMS_PER_ROW = 4;
    localparam int ELEMS_PER_JOB = ROWS_PER_JOB * ELEMS_PER_ROW;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        DRAIN,
        HOLD
    } pack_state_t;

endpackage

// File: rtl/mapu_row_buf.sv
// Two-stage row buffer: a fill register collecting scalar elements and a hold
// register presenting one complete row, each side with vld/rdy handshaking.
module mapu_row_buf
    import mapu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_r0,
    output logic [DATA_WIDTH-1:0] out_r1,
    output logic [DATA_WIDTH-1:0] out_r2,
    output logic [DATA_WIDTH-1:0] out_r3
);

    logic [DATA_WIDTH-1:0] fill_elem [ELEMS_PER_ROW];
    logic [DATA_WIDTH-1:0] hold_elem [ELEMS_PER_ROW];
    logic [1:0]            fill_idx;
    logic                  fill_full;
    logic                  hold_vld;

    logic in_acc;
    logic out_acc;
    logic hold_free;
    logic row_done;
    logic bypass;
    logic promote;

    assign in_rdy    = !(fill_full && hold_vld);
    assign in_acc    = in_vld && in_rdy;
    assign out_acc   = hold_vld && out_rdy;
    assign hold_free = !hold_vld || out_rdy;
    assign row_done  = in_acc && (fill_idx == 2'd3);

    // The 4th element goes straight into hold when it can, so m_vld follows
    // the last accept by one cycle; otherwise the row parks in fill.
    assign bypass  = row_done && hold_free;
    assign promote = fill_full && hold_free;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ELEMS_PER_ROW; i++) begin
                fill_elem[i] <= '0;
                hold_elem[i] <= '0;
            end
            fill_idx  <= '0;
            fill_full <= 1'b0;
            hold_vld  <= 1'b0;
        end else begin
            if (in_acc) begin
                fill_elem[fill_idx] <= in_data;
                fill_idx            <= fill_idx + 2'd1;
            end

            if (promote) begin
                fill_full <= 1'b0;
            end else if (row_done && !hold_free) begin
                fill_full <= 1'b1;
            end

            if (promote) begin
                hold_elem <= fill_elem;
            end else if (bypass) begin
                hold_elem[0] <= fill_elem[0];
                hold_elem[1] <= fill_elem[1];
                hold_elem[2] <= fill_elem[2];
                hold_elem[3] <= in_data;
            end

            if (promote || bypass) begin
                hold_vld <= 1'b1;
            end else if (out_acc) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign out_vld = hold_vld;
    assign out_r0  = hold_elem[0];
    assign out_r1  = hold_elem[1];
    assign out_r2  = hold_elem[2];
    assign out_r3  = hold_elem[3];

endmodule

// File: rtl/mapu_row_packer.sv
// Packs a scalar element stream into 8 four-element rows per APU job (A then B),
// padding short jobs with zeros, and drives the APU enable/op lines.
module mapu_row_packer
    import mapu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EN_HOLD    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_vld,
    output logic                  s_rdy,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_op,
    input  logic                  s_last,
    output logic                  m_vld,
    input  logic                  m_rdy,
    output logic [DATA_WIDTH-1:0] m_r0,
    output logic [DATA_WIDTH-1:0] m_r1,
    output logic [DATA_WIDTH-1:0] m_r2,
    output logic [DATA_WIDTH-1:0] m_r3,
    output logic                  m_en,
    output logic                  m_op,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int                HOLD_W    = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EN_HOLD - 1);
    localparam logic [4:0]        LAST_ELEM = 5'(ELEMS_PER_JOB - 1);
    localparam logic [2:0]        LAST_ROW  = 3'(ROWS_PER_JOB - 1);

    pack_state_t state;
    pack_state_t state_nxt;

    logic              started;
    logic [4:0]        elem_cnt;
    logic [2:0]        row_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              op_q;
    logic              busy_q;
    logic              en_q;
    logic              err_q;
    logic              err_nxt;

    logic                  buf_in_vld;
    logic                  buf_in_rdy;
    logic [DATA_WIDTH-1:0] buf_in_data;
    logic                  accepting;
    logic                  elem_acc;
    logic                  row_hs;
    logic                  at_last;

    // External elements only enter in IDLE/FILL; PAD feeds zeros internally.
    assign accepting   = started && ((state == IDLE) || (state == FILL));
    assign s_rdy       = accepting && buf_in_rdy;
    assign buf_in_vld  = (state == PAD) || (accepting && s_vld);
    assign buf_in_data = (state == PAD) ? '0 : s_data;
    assign elem_acc    = buf_in_vld && buf_in_rdy;
    assign row_hs      = m_vld && m_rdy;
    assign at_last     = (elem_cnt == LAST_ELEM);

    mapu_row_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_row_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (buf_in_vld),
        .in_rdy  (buf_in_rdy),
        .in_data (buf_in_data),
        .out_vld (m_vld),
        .out_rdy (m_rdy),
        .out_r0  (m_r0),
        .out_r1  (m_r1),
        .out_r2  (m_r2),
        .out_r3  (m_r3)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (elem_acc) begin
                    if (at_last) begin
                        state_nxt = DRAIN;
                        err_nxt   = !s_last;
                    end else if (s_last) begin
                        state_nxt = PAD;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            PAD: begin
                if (elem_acc && at_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (row_hs && (row_cnt == LAST_ROW)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element and row counters wrap to zero at the end of every job, so IDLE
    // always starts from a clean count without an explicit clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            started  <= 1'b0;
            elem_cnt <= '0;
            row_cnt  <= '0;
            hold_cnt <= '0;
            op_q     <= 1'b0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            started <= 1'b1;
            err_q   <= err_nxt;

            if (elem_acc) begin
                elem_cnt <= elem_cnt + 5'd1;
            end
            if (row_hs) begin
                row_cnt <= row_cnt + 3'd1;
                en_q    <= 1'b1;
            end
            if ((state == IDLE) && elem_acc) begin
                op_q   <= s_op;
                busy_q <= 1'b1;
            end
            if (state == HOLD) begin
                if (state_nxt == IDLE) begin
                    hold_cnt <= '0;
                    en_q     <= 1'b0;
                    busy_q   <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

    // Enable covers the first row handshake cycle itself, not just the ones after it.
    assign m_en   = en_q || row_hs;
    assign m_op   = op_q;
    assign o_busy = busy_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_mapu_row_packer.sv
// Directed bench for mapu_row_packer: full, stalled, short, unterminated and
// reset-interrupted jobs with hand-derived row contents and timing.
module tb_mapu_row_packer;
    import mapu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          s_vld;
    logic          s_rdy;
    logic [DW-1:0] s_data;
    logic          s_op;
    logic          s_last;
    logic          m_vld;
    logic          m_rdy;
    logic [DW-1:0] m_r0;
    logic [DW-1:0] m_r1;
    logic [DW-1:0] m_r2;
    logic [DW-1:0] m_r3;
    logic          m_en;
    logic          m_op;
    logic          o_busy;
    logic          o_err;

    int total  = 0;
    int passed = 0;

    logic [127:0] rows [8];
    int rows_seen, err_cnt, en_cnt, op_bad, unstable, early_acc;
    int first_stall, c4, first_vld, row_c0, row_c7, acc_c0, acc_c31;
    logic done, late_rdy;

    always #5 clk = ~clk;

    mapu_row_packer #(
        .DATA_WIDTH(DW),
        .EN_HOLD   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_vld   (s_vld),
        .s_rdy   (s_rdy),
        .s_data  (s_data),
        .s_op    (s_op),
        .s_last  (s_last),
        .m_vld   (m_vld),
        .m_rdy   (m_rdy),
        .m_r0    (m_r0),
        .m_r1    (m_r1),
        .m_r2    (m_r2),
        .m_r3    (m_r3),
        .m_en    (m_en),
        .m_op    (m_op),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one job element by element on the falling edge and records what
    // the DUT does on each rising edge. Exits when o_busy falls, or after
    // abort_rows row handshakes when abort_rows > 0.
    task automatic run_job(input int n_send, input int last_at, input logic op,
                           input bit toggle, input int stall_lo, input int stall_hi,
                           input int abort_rows);
        int idx;
        bit busy_seen;
        bit hold_pend;
        logic [127:0] held;
        idx = 0;
        busy_seen = 0;
        hold_pend = 0;
        held = '0;
        for (int k = 0; k < 8; k++) rows[k] = 'x;
        rows_seen = 0; err_cnt = 0; en_cnt = 0; op_bad = 0; unstable = 0; early_acc = 0;
        first_stall = -1; c4 = -1; first_vld = -1; row_c0 = -1; row_c7 = -1;
        acc_c0 = -1; acc_c31 = -1;
        done = 1'b0; late_rdy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            m_rdy  = !(c >= stall_lo && c <= stall_hi);
            s_vld  = (idx < n_send);
            s_data = DW'(idx + 1);
            s_last = (idx + 1 == last_at);
            s_op   = (toggle && idx > 0) ? idx[0] : op;
            #1;
            if (hold_pend && (m_vld !== 1'b1 || {m_r0, m_r1, m_r2, m_r3} !== held)) unstable++;
            hold_pend = m_vld && !m_rdy;
            held = {m_r0, m_r1, m_r2, m_r3};
            if (o_busy === 1'b1) busy_seen = 1;
            if (busy_seen && o_busy === 1'b0 && abort_rows == 0) begin
                late_rdy = s_vld && s_rdy;
                done = 1'b1;
                break;
            end
            if (s_vld && !s_rdy && first_stall < 0 && idx > 0) first_stall = c;
            if (s_vld && s_rdy) begin
                if (idx >= 32 && o_busy) early_acc++;
                if (idx == 0) acc_c0 = c;
                if (idx == 3) c4 = c;
                if (idx == 31) acc_c31 = c;
                idx++;
            end
            if (m_vld && first_vld < 0) first_vld = c;
            if (m_vld && m_rdy) begin
                if (rows_seen < 8) rows[rows_seen] = {m_r0, m_r1, m_r2, m_r3};
                if (rows_seen == 0) row_c0 = c;
                if (rows_seen == 7) row_c7 = c;
                rows_seen++;
            end
            if (o_err) err_cnt++;
            if (m_en) en_cnt++;
            if (o_busy && m_op !== op) op_bad++;
            if (abort_rows > 0 && rows_seen == abort_rows) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    // Expected row k holds elements 4k+1..4k+4, zeroed past the last real element.
    task automatic chk_rows(input string tag, input int last_valid);
        logic [127:0] exp;
        int v;
        chk($sformatf("%s_row_count", tag), 128'(rows_seen), 128'(8));
        for (int k = 0; k < 8; k++) begin
            exp = '0;
            for (int j = 0; j < 4; j++) begin
                v = 4 * k + j + 1;
                exp = {exp[95:0], (v <= last_valid) ? DW'(v) : DW'(0)};
            end
            chk($sformatf("%s_row%0d", tag, k), rows[k], exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        s_vld   = 1'b0;
        s_data  = '0;
        s_op    = 1'b0;
        s_last  = 1'b0;
        m_rdy   = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_rdy", 128'(s_rdy), 128'(0));
        chk("rst_m_vld", 128'(m_vld), 128'(0));
        chk("rst_m_row", 128'({m_r0, m_r1, m_r2, m_r3}), 128'(0));
        chk("rst_m_en", 128'(m_en), 128'(0));
        chk("rst_m_op", 128'(m_op), 128'(0));
        chk("rst_o_busy", 128'(o_busy), 128'(0));
        chk("rst_o_err", 128'(o_err), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_s_rdy", 128'(s_rdy), 128'(1));

        // Basic job: 1..32, ADD, no stalls
        run_job(32, 32, MAPU_OP_ADD, 0, -1, -2, 0);
        chk("basic_done", 128'(done), 128'(1));
        chk_rows("basic", 32);
        chk("basic_err", 128'(err_cnt), 128'(0));
        chk("basic_op", 128'(op_bad), 128'(0));
        chk("basic_first_vld_cycle", 128'(first_vld), 128'(4));
        chk("basic_4th_accept_cycle", 128'(c4), 128'(3));
        chk("basic_first_row_cycle", 128'(row_c0), 128'(4));
        chk("basic_last_row_cycle", 128'(row_c7), 128'(32));
        chk("basic_elem_rate", 128'(acc_c31 - acc_c0), 128'(31));
        chk("basic_en_cycles", 128'(en_cnt), 128'(37));

        // Back-pressure: m_rdy low in cycles 3..10
        run_job(32, 32, MAPU_OP_ADD, 0, 3, 10, 0);
        chk("bp_done", 128'(done), 128'(1));
        chk_rows("bp", 32);
        chk("bp_first_stall", 128'(first_stall), 128'(8));
        chk("bp_stable", 128'(unstable), 128'(0));
        chk("bp_err", 128'(err_cnt), 128'(0));

        // Op latch: s_op toggles after element 0 of a MULT job
        run_job(32, 32, MAPU_OP_MULT, 1, -1, -2, 0);
        chk("oplatch_done", 128'(done), 128'(1));
        chk_rows("oplatch", 32);
        chk("oplatch_op", 128'(op_bad), 128'(0));

        // Short job: s_last on element 10, MULT
        run_job(10, 10, MAPU_OP_MULT, 0, -1, -2, 0);
        chk("short_done", 128'(done), 128'(1));
        chk_rows("short", 10);
        chk("short_err", 128'(err_cnt), 128'(1));
        chk("short_op", 128'(op_bad), 128'(0));

        // Missing last: 33 elements offered, no s_last
        run_job(33, 0, MAPU_OP_ADD, 0, -1, -2, 0);
        chk("nolast_done", 128'(done), 128'(1));
        chk_rows("nolast", 32);
        chk("nolast_err", 128'(err_cnt), 128'(1));
        chk("nolast_early_accept", 128'(early_acc), 128'(0));
        chk("nolast_late_accept", 128'(late_rdy), 128'(1));
        @(negedge clk);
        s_vld = 1'b0;

        // Reset mid-job after 3 rows
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_job(32, 32, MAPU_OP_MULT, 0, -1, -2, 3);
        chk("midrst_reach3", 128'(done), 128'(1));
        @(negedge clk);
        reset_n = 1'b0;
        s_vld   = 1'b0;
        m_rdy   = 1'b1;
        @(negedge clk);
        chk("midrst_m_vld", 128'(m_vld), 128'(0));
        chk("midrst_m_en", 128'(m_en), 128'(0));
        chk("midrst_o_busy", 128'(o_busy), 128'(0));
        chk("midrst_s_rdy", 128'(s_rdy), 128'(0));
        chk("midrst_m_row", 128'({m_r0, m_r1, m_r2, m_r3}), 128'(0));
        chk("midrst_m_op", 128'(m_op), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_s_rdy", 128'(s_rdy), 128'(1));
        chk("midrst_no_partial_row", 128'(m_vld), 128'(0));
        run_job(32, 32, MAPU_OP_ADD, 0, -1, -2, 0);
        chk("after_rst_done", 128'(done), 128'(1));
        chk_rows("after_rst", 32);
        chk("after_rst_err", 128'(err_cnt), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
